// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment types, active-high glyph table and polarity helper
//   seg_t      7-bit segment vector, bit0 = a ... bit6 = g
//   SEG_GLYPH  hex glyphs 0-9, A, b, C, d, E, F (1 = segment lit)
//   SEG_OFF    all segments dark (active-high)
//   to_level   maps an active-high bit onto the pin polarity
package seg_pkg;
    typedef logic [6:0] seg_t;
    localparam seg_t SEG_OFF = 7'h00;
    localparam seg_t SEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    function automatic logic to_level(input bit active_low, input logic v);
        return active_low ? ~v : v;
    endfunction
endpackage

// File: rtl/seg_display_mux_if.sv
// seg_display_mux_if: register-side inputs and board-side outputs of the display driver
//   value/dp_in/blank_in/lz_en/bright  master -> slave, sampled once per frame
//   an/seg/dp/frame_tick               slave -> master, display pins and frame pulse
interface seg_display_mux_if import seg_pkg::*; #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    lz_en;
    logic [BRIGHT_W-1:0]     bright;
    logic [NUM_DIGITS-1:0]   an;
    seg_t                    seg;
    logic                    dp;
    logic                    frame_tick;
    modport master (output value, dp_in, blank_in, lz_en, bright, input an, seg, dp, frame_tick);
    modport slave (input value, dp_in, blank_in, lz_en, bright, output an, seg, dp, frame_tick);
endinterface

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: combinational hex nibble to active-high 7-segment glyph
//   nib_i  hex digit
//   seg_o  glyph, bit0 = a ... bit6 = g
module seg_hex_decoder import seg_pkg::*; (
    input  logic [3:0] nib_i,
    output seg_t       seg_o
);
    assign seg_o = SEG_GLYPH[nib_i];
endmodule

// File: rtl/seg_display_mux.sv
// seg_display_mux: time-multiplexed N-digit 7-segment driver with frame snapshot, PWM and guard
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         slave side of seg_display_mux_if (inputs sampled at frame edge, registered pins out)
module seg_display_mux import seg_pkg::*; #(
    parameter int NUM_DIGITS     = 4,
    parameter int CPD            = 25000,
    parameter int GUARD          = 2,
    parameter int BRIGHT_W       = 4,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    seg_display_mux_if.slave bus
);
    localparam int TW = $clog2(CPD + 1);
    localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam seg_t SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

    logic [TW-1:0]           tick_q, tick_d, on_len_q, on_len_d;
    logic [DW-1:0]           digit_q, digit_d;
    logic                    load_pend_q;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   dp_snap_q, blank_q, lz_sup;
    logic                    lz_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    seg_t                    seg_q, seg_d, glyph;
    logic                    dp_q, dp_d, ft_q;
    logic                    wrap, snap, win, seg_on, dp_on, run;

    assign wrap = tick_q == TW'(CPD - 1);
    // Frame edge closes digit 0's last cycle; load_pend forces one capture right after reset.
    assign snap = load_pend_q || (wrap && digit_q == '0);
    assign tick_d = wrap ? '0 : tick_q + 1'b1;
    assign digit_d = wrap ? (digit_q == '0 ? DW'(NUM_DIGITS - 1) : digit_q - 1'b1) : digit_q;
    assign on_len_d = &bus.bright ? TW'(CPD) : TW'((CPD * int'(bus.bright)) >> BRIGHT_W);

    // A digit is suppressed while every nibble from the top down to it is zero.
    always_comb begin
        lz_sup = '0;
        run = lz_q;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run = run && (value_q[4*i +: 4] == 4'h0);
            lz_sup[i] = run && (i != 0);
        end
    end

    seg_hex_decoder u_dec (
        .nib_i (value_q[4*digit_q +: 4]),
        .seg_o (glyph)
    );

    assign win = tick_q >= TW'(GUARD) && tick_q < on_len_q && !blank_q[digit_q];
    assign seg_on = win && !lz_sup[digit_q];
    assign dp_on = win && dp_snap_q[digit_q];

    always_comb begin
        an_d = '0;
        seg_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            an_d[i] = to_level(AN_ACTIVE_LOW, (seg_on || dp_on) && digit_q == DW'(i));
        for (int i = 0; i < 7; i++)
            seg_d[i] = to_level(SEG_ACTIVE_LOW, seg_on && glyph[i]);
        dp_d = to_level(SEG_ACTIVE_LOW, dp_on);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q      <= '0;
            digit_q     <= DW'(NUM_DIGITS - 1);
            load_pend_q <= 1'b1;
            value_q     <= '0;
            dp_snap_q   <= '0;
            blank_q     <= '0;
            lz_q        <= 1'b0;
            on_len_q    <= '0;
            an_q        <= AN_IDLE;
            seg_q       <= SEG_IDLE;
            dp_q        <= SEG_ACTIVE_LOW;
            ft_q        <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            digit_q     <= digit_d;
            load_pend_q <= 1'b0;
            ft_q        <= snap;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            if (snap) begin
                value_q   <= bus.value;
                dp_snap_q <= bus.dp_in;
                blank_q   <= bus.blank_in;
                lz_q      <= bus.lz_en;
                on_len_q  <= on_len_d;
            end
        end
    end

    assign bus.an = an_q;
    assign bus.seg = seg_q;
    assign bus.dp = dp_q;
    assign bus.frame_tick = ft_q;
endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: directed self-checking bench for seg_display_mux (4-digit active-low and 8-digit active-high)
module tb_seg_display_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n_b = 1'b0;
    int checks = 0;
    int passes = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seg_display_mux_if #(.NUM_DIGITS(4), .BRIGHT_W(4)) ifa ();
    seg_display_mux_if #(.NUM_DIGITS(8), .BRIGHT_W(4)) ifb ();

    seg_display_mux #(
        .NUM_DIGITS(4), .CPD(8), .GUARD(2), .BRIGHT_W(4),
        .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    seg_display_mux #(
        .NUM_DIGITS(8), .CPD(8), .GUARD(2), .BRIGHT_W(4),
        .AN_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (ifb)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Walks one 8-cycle digit slot; g is the expected active-high glyph (0 = no segments),
    // p the expected dp, lit only for slot cycles lo..hi.
    task automatic slot(input bit b, input int d, input logic [6:0] g, input logic p,
                        input int lo, input int hi, input bit first);
        logic on, ft;
        logic [3:0] ea4;
        logic [7:0] ea8;
        logic [6:0] es;
        logic ed;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            on = t >= lo && t <= hi && (g != 7'h00 || p);
            ft = (first && t == 0) || (d == 0 && t == 7);
            if (b) begin
                ea8 = on ? 8'(1 << d) : 8'h00;
                es = on ? g : 7'h00;
                ed = on & p;
                chk($sformatf("B d%0d t%0d an", d, t), 32'(ifb.an), 32'(ea8));
                chk($sformatf("B d%0d t%0d seg", d, t), 32'(ifb.seg), 32'(es));
                chk($sformatf("B d%0d t%0d dp", d, t), 32'(ifb.dp), 32'(ed));
                chk($sformatf("B d%0d t%0d ft", d, t), 32'(ifb.frame_tick), 32'(ft));
            end else begin
                ea4 = on ? ~4'(1 << d) : 4'hF;
                es = on ? ~g : 7'h7F;
                ed = ~(on & p);
                chk($sformatf("A d%0d t%0d an", d, t), 32'(ifa.an), 32'(ea4));
                chk($sformatf("A d%0d t%0d seg", d, t), 32'(ifa.seg), 32'(es));
                chk($sformatf("A d%0d t%0d dp", d, t), 32'(ifa.dp), 32'(ed));
                chk($sformatf("A d%0d t%0d ft", d, t), 32'(ifa.frame_tick), 32'(ft));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1);
    end

    initial begin
        ifa.value = 16'h1234; ifa.dp_in = 4'b0000; ifa.blank_in = 4'b0000;
        ifa.lz_en = 1'b0; ifa.bright = 4'hF;
        ifb.value = 32'hDEADBEEF; ifb.dp_in = 8'h00; ifb.blank_in = 8'h00;
        ifb.lz_en = 1'b0; ifb.bright = 4'hF;
        repeat (2) @(negedge clk);
        chk("reset A an", 32'(ifa.an), 32'h0000000F);
        chk("reset A seg", 32'(ifa.seg), 32'h0000007F);
        chk("reset A dp", 32'(ifa.dp), 32'h00000001);
        chk("reset A ft", 32'(ifa.frame_tick), 32'h00000000);
        chk("reset B an", 32'(ifb.an), 32'h00000000);
        chk("reset B seg", 32'(ifb.seg), 32'h00000000);
        chk("reset B dp", 32'(ifb.dp), 32'h00000000);
        rst_n = 1'b1;
        // Frame 1: 1234 at full brightness
        slot(0, 3, 7'h06, 0, 2, 7, 1);
        slot(0, 2, 7'h5B, 0, 2, 7, 0);
        slot(0, 1, 7'h4F, 0, 2, 7, 0);
        ifa.value = 16'h00A0; ifa.lz_en = 1'b1; ifa.dp_in = 4'b0100;
        slot(0, 0, 7'h66, 0, 2, 7, 0);
        // Frame 2: leading zeros suppressed, digit 2 shows only its dp
        slot(0, 3, 7'h00, 0, 2, 7, 0);
        slot(0, 2, 7'h00, 1, 2, 7, 0);
        slot(0, 1, 7'h77, 0, 2, 7, 0);
        ifa.lz_en = 1'b0; ifa.dp_in = 4'b0000;
        slot(0, 0, 7'h3F, 0, 2, 7, 0);
        // Frame 3: leading zeros shown
        slot(0, 3, 7'h3F, 0, 2, 7, 0);
        slot(0, 2, 7'h3F, 0, 2, 7, 0);
        slot(0, 1, 7'h77, 0, 2, 7, 0);
        ifa.value = 16'h1234; ifa.bright = 4'h8;
        slot(0, 0, 7'h3F, 0, 2, 7, 0);
        // Frame 4: half brightness, on_len = 4
        slot(0, 3, 7'h06, 0, 2, 3, 0);
        slot(0, 2, 7'h5B, 0, 2, 3, 0);
        slot(0, 1, 7'h4F, 0, 2, 3, 0);
        ifa.bright = 4'h0;
        slot(0, 0, 7'h66, 0, 2, 3, 0);
        // Frame 5: brightness 0, fully dark
        slot(0, 3, 7'h06, 0, 8, 8, 0);
        slot(0, 2, 7'h5B, 0, 8, 8, 0);
        slot(0, 1, 7'h4F, 0, 8, 8, 0);
        ifa.bright = 4'hF;
        slot(0, 0, 7'h66, 0, 8, 8, 0);
        // Frame 6: inputs change mid-frame, display keeps the snapshot
        slot(0, 3, 7'h06, 0, 2, 7, 0);
        ifa.value = 16'h5678; ifa.blank_in = 4'b0010;
        slot(0, 2, 7'h5B, 0, 2, 7, 0);
        slot(0, 1, 7'h4F, 0, 2, 7, 0);
        slot(0, 0, 7'h66, 0, 2, 7, 0);
        // Frame 7: new value, digit 1 blanked
        slot(0, 3, 7'h6D, 0, 2, 7, 0);
        slot(0, 2, 7'h7D, 0, 2, 7, 0);
        slot(0, 1, 7'h00, 0, 2, 7, 0);
        slot(0, 0, 7'h7F, 0, 2, 7, 0);
        // Frame 8: reset pulled in the lit part of digit 3
        repeat (4) @(negedge clk);
        chk("pre-reset an", 32'(ifa.an), 32'h00000007);
        chk("pre-reset seg", 32'(ifa.seg), 32'h00000012);
        ifa.value = 16'h9ABC; ifa.blank_in = 4'b0000;
        rst_n = 1'b0;
        #1;
        chk("async reset an", 32'(ifa.an), 32'h0000000F);
        chk("async reset seg", 32'(ifa.seg), 32'h0000007F);
        chk("async reset dp", 32'(ifa.dp), 32'h00000001);
        chk("async reset ft", 32'(ifa.frame_tick), 32'h00000000);
        repeat (2) @(negedge clk);
        chk("held reset an", 32'(ifa.an), 32'h0000000F);
        rst_n = 1'b1;
        slot(0, 3, 7'h6F, 0, 2, 7, 1);
        slot(0, 2, 7'h77, 0, 2, 7, 0);
        slot(0, 1, 7'h7C, 0, 2, 7, 0);
        slot(0, 0, 7'h39, 0, 2, 7, 0);
        // 8-digit active-high instance showing DEADBEEF
        rst_n_b = 1'b1;
        slot(1, 7, 7'h5E, 0, 2, 7, 1);
        slot(1, 6, 7'h79, 0, 2, 7, 0);
        slot(1, 5, 7'h77, 0, 2, 7, 0);
        slot(1, 4, 7'h5E, 0, 2, 7, 0);
        slot(1, 3, 7'h7C, 0, 2, 7, 0);
        slot(1, 2, 7'h79, 0, 2, 7, 0);
        slot(1, 1, 7'h79, 0, 2, 7, 0);
        slot(1, 0, 7'h71, 0, 2, 7, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
